// File: rtl/memShare_config_pkg.sv
// Shared types and default sizing for the memShare pipeline sequencer.
// Pure declarations; no timing or flow-control behaviour.
package memShare_config_pkg;

   localparam int PIPE_STAGE_NUM_DEF = 3;
   localparam int ROUND_MAX_DEF      = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } memShare_seq_state_t;

endpackage

// File: rtl/memShare_wrap_counter.sv
// Modulo-MOD counter with enable and clear; wrap_o flags the enabled step from MOD-1 back to 0.
// Count updates one cycle after en_i; clr_i wins over en_i.
module memShare_wrap_counter #(
   parameter int MOD = 3,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = en_i && (cnt_q == W'(MOD - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/memshare_pipe_sequencer.sv
// Sequences SCU.memShare() pipeline cycles: PIPE_STAGE_NUM stages per round, up to ROUND_MAX rounds.
// Run begins one cycle after start_i; stall_i freezes the counters; flush_i aborts to IDLE next edge.
module memshare_pipe_sequencer
   import memShare_config_pkg::*;
#(
   parameter  int PIPE_STAGE_NUM = PIPE_STAGE_NUM_DEF,
   parameter  int ROUND_MAX      = ROUND_MAX_DEF,
   localparam int STAGE_W        = $clog2(PIPE_STAGE_NUM),
   localparam int ROUND_W        = $clog2(ROUND_MAX + 1)
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [ROUND_W-1:0] round_num_i,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic               pipeCycle_begin_o,
   output logic [STAGE_W-1:0] stage_idx_o,
   output logic [ROUND_W-1:0] round_idx_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [ROUND_W-1:0] ROUND_MAX_W = ROUND_W'(ROUND_MAX);

   memShare_seq_state_t state_q;
   memShare_seq_state_t state_d;
   logic [ROUND_W-1:0]  round_q;
   logic [ROUND_W-1:0]  round_d;
   logic [ROUND_W-1:0]  limit_q;
   logic [ROUND_W-1:0]  limit_d;
   logic                stage_en;
   logic                stage_clr;
   logic                stage_wrap;
   logic [STAGE_W-1:0]  stage_idx;

   memShare_wrap_counter #(
      .MOD (PIPE_STAGE_NUM),
      .W   (STAGE_W)
   ) u_stage_cnt (
      .clk    (sys_clk),
      .rst    (rst),
      .en_i   (stage_en),
      .clr_i  (stage_clr),
      .cnt_o  (stage_idx),
      .wrap_o (stage_wrap)
   );

   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      limit_d   = limit_q;
      stage_en  = 1'b0;
      stage_clr = 1'b0;
      if (flush_i) begin
         state_d   = ST_IDLE;
         round_d   = '0;
         limit_d   = '0;
         stage_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  round_d   = '0;
                  stage_clr = 1'b1;
                  if (round_num_i == '0) begin
                     state_d = ST_DONE;
                     limit_d = '0;
                  end else begin
                     state_d = ST_RUN;
                     limit_d = (round_num_i > ROUND_MAX_W) ? ROUND_MAX_W : round_num_i;
                  end
               end
            end
            ST_RUN: begin
               if (!stall_i) begin
                  stage_en = 1'b1;
                  // Round index is left at the limit so DONE reports how many rounds ran.
                  if (stage_wrap) begin
                     round_d = round_q + ROUND_W'(1);
                     if (round_q == limit_q - ROUND_W'(1)) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               round_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         limit_q <= limit_d;
      end
   end

   assign stage_idx_o       = stage_idx;
   assign round_idx_o       = round_q;
   assign busy_o            = (state_q == ST_RUN);
   assign done_o            = (state_q == ST_DONE);
   assign pipeCycle_begin_o = (state_q == ST_RUN) && (stage_idx == '0) && !stall_i;

endmodule

// File: tb/tb_memshare_pipe_sequencer.sv
// Randomised and directed bench for memshare_pipe_sequencer against a cycle-count reference model.
module tb_memshare_pipe_sequencer;

   localparam int P    = 3;
   localparam int RMAX = 16;
   localparam int SW   = $clog2(P);
   localparam int RW   = $clog2(RMAX + 1);
   localparam int VW   = 1 + SW + RW + 2;

   logic          sys_clk;
   logic          rst;
   logic          start_i;
   logic [RW-1:0] round_num_i;
   logic          stall_i;
   logic          flush_i;
   logic          pipeCycle_begin_o;
   logic [SW-1:0] stage_idx_o;
   logic [RW-1:0] round_idx_o;
   logic          busy_o;
   logic          done_o;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0=idle 1=run 2=done; k counts unstalled RUN cycles of the run.
   int m_mode = 0;
   int m_k    = 0;
   int m_lim  = 0;

   memshare_pipe_sequencer #(
      .PIPE_STAGE_NUM (P),
      .ROUND_MAX      (RMAX)
   ) dut (
      .sys_clk           (sys_clk),
      .rst               (rst),
      .start_i           (start_i),
      .round_num_i       (round_num_i),
      .stall_i           (stall_i),
      .flush_i           (flush_i),
      .pipeCycle_begin_o (pipeCycle_begin_o),
      .stage_idx_o       (stage_idx_o),
      .round_idx_o       (round_idx_o),
      .busy_o            (busy_o),
      .done_o            (done_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // One clock cycle: drive inputs, report observed and model-predicted outputs, advance the model.
   task automatic step(input logic s, input int n, input logic st, input logic fl,
                       output logic [VW-1:0] act, output logic [VW-1:0] exp);
      int nn;
      @(negedge sys_clk);
      nn          = n % (1 << RW);
      start_i     = s;
      round_num_i = RW'(nn);
      stall_i     = st;
      flush_i     = fl;
      #1;
      exp = {(m_mode == 1) && ((m_k % P) == 0) && !st, SW'(m_k % P), RW'(m_k / P),
             (m_mode == 1), (m_mode == 2)};
      act = {pipeCycle_begin_o, stage_idx_o, round_idx_o, busy_o, done_o};
      @(posedge sys_clk);
      if (fl) begin
         m_mode = 0;
         m_k    = 0;
      end else if (m_mode == 0) begin
         if (s) begin
            m_k    = 0;
            m_mode = (nn == 0) ? 2 : 1;
            m_lim  = (nn > RMAX) ? RMAX : nn;
         end
      end else if (m_mode == 1) begin
         if (!st) begin
            m_k = m_k + 1;
            if (m_k == m_lim * P) m_mode = 2;
         end
      end else begin
         m_mode = 0;
         m_k    = 0;
      end
   endtask

   task automatic test_reset();
      logic [VW-1:0] a, e;
      rst = 1'b1; start_i = 1'b0; round_num_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      @(negedge sys_clk);
      #1;
      a = {pipeCycle_begin_o, stage_idx_o, round_idx_o, busy_o, done_o};
      total++;
      if (a !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", a); end
      @(negedge sys_clk);
      rst = 1'b0;
      m_mode = 0; m_k = 0; m_lim = 0;
      step(1'b0, 0, 1'b0, 1'b0, a, e);
      total++;
      if (a !== e) begin bad++; $display("FAIL reset_idle got=%h want=%h", a, e); end
   endtask

   task automatic test_two_rounds();
      logic [VW-1:0] a, e;
      logic [31:0]   bm, dm, um;
      bm = '0; dm = '0; um = '0;
      for (int t = 0; t < 10; t++) begin
         step(t == 0, 2, 1'b0, 1'b0, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL two_rounds cyc%0d got=%h want=%h", t, a, e); end
         bm[t] = a[VW-1]; um[t] = a[1]; dm[t] = a[0];
      end
      total++;
      if (bm !== 32'h12) begin bad++; $display("FAIL two_rounds_begin got=%h want=12", bm); end
      total++;
      if (dm !== 32'h80) begin bad++; $display("FAIL two_rounds_done got=%h want=80", dm); end
      total++;
      if (um !== 32'h7E) begin bad++; $display("FAIL two_rounds_busy got=%h want=7e", um); end
   endtask

   task automatic test_zero_rounds();
      logic [VW-1:0] a, e;
      logic [31:0]   bm, dm, um;
      bm = '0; dm = '0; um = '0;
      for (int t = 0; t < 4; t++) begin
         step(t == 0, 0, 1'b0, 1'b0, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL zero_rounds cyc%0d got=%h want=%h", t, a, e); end
         bm[t] = a[VW-1]; um[t] = a[1]; dm[t] = a[0];
      end
      total++;
      if ({bm, um, dm} !== {32'h0, 32'h0, 32'h2}) begin
         bad++; $display("FAIL zero_rounds_pulses got=%h/%h/%h want=0/0/2", bm, um, dm);
      end
   endtask

   task automatic test_stall();
      logic [VW-1:0] a, e;
      logic [31:0]   bm, dm;
      bm = '0; dm = '0;
      for (int t = 0; t < 10; t++) begin
         step(t == 0, 1, (t >= 1) && (t <= 3), 1'b0, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL stall cyc%0d got=%h want=%h", t, a, e); end
         bm[t] = a[VW-1]; dm[t] = a[0];
      end
      total++;
      if (bm !== 32'h10) begin bad++; $display("FAIL stall_begin got=%h want=10", bm); end
      total++;
      if (dm !== 32'h80) begin bad++; $display("FAIL stall_done got=%h want=80", dm); end
   endtask

   task automatic test_saturate();
      logic [VW-1:0] a, e;
      int            nb, nd, dcyc;
      nb = 0; nd = 0; dcyc = -1;
      for (int t = 0; t < 52; t++) begin
         step(t == 0, RMAX + 5, 1'b0, 1'b0, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL saturate cyc%0d got=%h want=%h", t, a, e); end
         if (a[VW-1] === 1'b1) nb++;
         if (a[0] === 1'b1) begin nd++; dcyc = t; end
      end
      total++;
      if (nb !== RMAX) begin bad++; $display("FAIL saturate_begins got=%0d want=%0d", nb, RMAX); end
      total++;
      if (nd !== 1 || dcyc !== RMAX * P + 1) begin
         bad++; $display("FAIL saturate_done count=%0d cyc=%0d want 1 at %0d", nd, dcyc, RMAX * P + 1);
      end
   endtask

   task automatic test_flush();
      logic [VW-1:0] a, e;
      logic [31:0]   bm, dm, um;
      bm = '0; dm = '0; um = '0;
      for (int t = 0; t < 12; t++) begin
         step((t == 0) || (t == 5), (t == 0) ? 4 : 1, 1'b0, t == 3, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL flush cyc%0d got=%h want=%h", t, a, e); end
         bm[t] = a[VW-1]; um[t] = a[1]; dm[t] = a[0];
      end
      total++;
      if (um !== 32'h1CE) begin bad++; $display("FAIL flush_busy got=%h want=1ce", um); end
      total++;
      if (dm !== 32'h200) begin bad++; $display("FAIL flush_done got=%h want=200", dm); end
      total++;
      if (bm !== 32'h42) begin bad++; $display("FAIL flush_begin got=%h want=42", bm); end
   endtask

   task automatic test_async_reset();
      logic [VW-1:0] a, e;
      for (int t = 0; t < 3; t++) begin
         step(t == 0, 2, 1'b0, 1'b0, a, e);
         total++;
         if (a !== e) begin bad++; $display("FAIL async_pre cyc%0d got=%h want=%h", t, a, e); end
      end
      @(negedge sys_clk);
      start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      a = {pipeCycle_begin_o, stage_idx_o, round_idx_o, busy_o, done_o};
      total++;
      if (a !== '0) begin bad++; $display("FAIL async_reset got=%h want=0", a); end
      @(negedge sys_clk);
      rst = 1'b0;
      m_mode = 0; m_k = 0; m_lim = 0;
      test_two_rounds();
   endtask

   task automatic test_random();
      logic [VW-1:0] a, e;
      int            nerr;
      nerr = 0;
      for (int t = 0; t < 400; t++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 20),
              $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, a, e);
         total++;
         if (a !== e) begin
            bad++;
            if (nerr < 10) $display("FAIL random cyc%0d got=%h want=%h", t, a, e);
            nerr++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_rounds();
      test_zero_rounds();
      test_stall();
      test_saturate();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memshare_pipe_sequencer.md
MEMSHARE_PIPE_SEQUENCER -- requirements
Module: memShare_pipe_sequencer

Interface
REQ-001 SHALL have parameter PIPE_STAGE_NUM, default 3: stages per SCU.memShare() pipeline cycle, legal range 2..8.
REQ-002 SHALL have parameter ROUND_MAX, default 16: maximum pipeline cycles per run.
REQ-003 SHALL have localparams STAGE_W = $clog2(PIPE_STAGE_NUM) and ROUND_W = $clog2(ROUND_MAX+1).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit: one-cycle request to begin a run.
REQ-007 SHALL have port round_num_i, input, ROUND_W bits: number of pipeline cycles requested, sampled with start_i.
REQ-008 SHALL have port stall_i, input, 1 bit: freezes sequencing while high.
REQ-009 SHALL have port flush_i, input, 1 bit: synchronous abort of the current run.
REQ-010 SHALL have port pipeCycle_begin_o, output, 1 bit: beginning of each SCU.memShare() pipeline cycle, consumed by memShare_monitor.
REQ-011 SHALL have port stage_idx_o, output, STAGE_W bits: current stage within the pipeline cycle.
REQ-012 SHALL have port round_idx_o, output, ROUND_W bits: current pipeline-cycle index.
REQ-013 SHALL have port busy_o, output, 1 bit: a run is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL go IDLE->RUN on start_i=1 with round_num_i>0, latching min(round_num_i, ROUND_MAX) as the round limit.
REQ-017 SHALL go IDLE->DONE on start_i=1 with round_num_i=0, producing a done_o pulse and no pipeCycle_begin_o.
REQ-018 SHALL ignore start_i in RUN and DONE.
REQ-019 SHALL enter RUN with stage_idx_o=0 and round_idx_o=0, one cycle after start_i.
REQ-020 SHALL, in RUN with stall_i=0, increment stage_idx_o each cycle; from PIPE_STAGE_NUM-1 it wraps to 0 and round_idx_o increments.
REQ-021 SHALL go RUN->DONE when the wrap from the last stage occurs on round limit-1; round_idx_o then holds the limit.
REQ-022 SHALL hold stage_idx_o and round_idx_o unchanged while stall_i=1.
REQ-023 SHALL drive pipeCycle_begin_o combinationally as (state==RUN)&&(stage_idx_o==0)&&!stall_i, giving exactly one pulse per round even when stalled.
REQ-024 SHALL assert done_o only in DONE, then go DONE->IDLE unconditionally; DONE lasts exactly one cycle.
REQ-025 SHALL assert busy_o in RUN only.
REQ-026 SHALL, when flush_i=1 in any state, go to IDLE on the next edge with counters cleared and no done_o pulse; flush_i takes priority over start_i and stall_i.
REQ-027 SHALL, when stall_i=1 and flush_i=1 together, flush.
REQ-028 SHALL give a run with limit N and no stalls exactly N*PIPE_STAGE_NUM RUN cycles, followed by one DONE cycle.

Reset
REQ-029 SHALL, on rst=1, asynchronously force state=IDLE, stage_idx_o=0, round_idx_o=0, round limit=0, busy_o=0 and done_o=0; pipeCycle_begin_o is then 0 by construction.
REQ-030 SHALL treat reset asserted mid-run as an abort: no done_o pulse, and the first start_i after release begins a fresh run.

Structure
REQ-031 SHALL place the FSM state enum (memShare_seq_state_t) and default PIPE_STAGE_NUM/ROUND_MAX constants in memShare_config_pkg.
REQ-032 SHALL implement the stage counter as one sub-module, memShare_wrap_counter (parameterised modulus, enable, clear, wrap pulse); the round counter is inline.

Verification
REQ-033 SHALL cover: start_i with round_num_i=2 at cycle 0 -> pipeCycle_begin_o high at cycles 1 and 4; done_o at cycle 7; busy_o high for cycles 1..6.
REQ-034 SHALL cover: round_num_i=0 -> done_o at cycle 1; busy_o and pipeCycle_begin_o never high.
REQ-035 SHALL cover: round_num_i=1 with stall_i high for cycles 1..3 -> pipeCycle_begin_o high only at cycle 4; done_o at cycle 7.
REQ-036 SHALL cover: round_num_i=ROUND_MAX+5 -> exactly ROUND_MAX begin pulses, then done_o.
REQ-037 SHALL cover: flush_i at cycle 3 of a 4-round run -> IDLE at cycle 4; no done_o; a start_i at cycle 5 starts a fresh run.
REQ-038 SHALL cover: rst pulsed asynchronously mid-cycle during RUN -> all outputs 0 immediately; start_i after release behaves as in REQ-033.
